nand4_resp_checker: RTL and testbench
=====================================

Name: nand4_resp_checker

Overview:
Synthesizable response checker for the NAND4 family. The stimulus side applies 4-bit vectors to the DUV; this block watches the applied vector and the DUV output and waits a programmable settle time. It then compares the output against the golden NAND4 function and records errors, the first failing vector, and vector coverage. It sits beside any NAND4 variant (equation, behaviour, self-component, primitive) and tells the bench when exhaustive coverage is done and whether the design passed.

Parameters:
SETTLE_CYCLES, 4, number of clock cycles waited after a new vector before sampling i_f (0 allowed).
ERR_W, 5, width of the error counter.
CHK_W, 8, width of the checks-performed counter.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_clr  input  1  synchronous clear; same effect as reset but takes effect on the clock edge.
i_vld  input  1  one-cycle strobe: a new vector is present on i_a..i_d this cycle.
i_a  input  1  applied vector bit, index MSB (weight 8).
i_b  input  1  applied vector bit (weight 4).
i_c  input  1  applied vector bit (weight 2).
i_d  input  1  applied vector bit, index LSB (weight 1).
i_f  input  1  DUV output o_f.
o_busy  output  1  high in SETTLE or SAMPLE.
o_done  output  1  high once all 16 vectors have been checked.
o_pass  output  1  o_done and error count is zero.
o_err_cnt  output  ERR_W  mismatch count, saturating.
o_chk_cnt  output  CHK_W  completed checks, saturating.
o_cov  output  16  bit k set once vector index k has been checked.
o_fail_vec  output  4  index of the first failing vector.
o_fail_vld  output  1  o_fail_vec is valid.

Behaviour:
- Reset (async, i_rst=1): state IDLE. All outputs are 0: o_busy, o_done, o_pass, o_err_cnt, o_chk_cnt, o_cov, o_fail_vec, o_fail_vld. The latched vector and settle counter are also 0.
- i_clr=1 at an edge has the same result as reset, has priority over all other inputs, and is ignored while i_rst=1.
- Vector index = {i_a,i_b,i_c,i_d}. Expected value = NOT(a AND b AND c AND d): 0 only for index 15.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: on an edge with i_vld=1, latch the index and load the settle counter with SETTLE_CYCLES. Go to SETTLE, or directly to SAMPLE if SETTLE_CYCLES=0.
- SETTLE: remains for exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
  - i_vld=1 in SETTLE relatches the new index and reloads the counter (restart). No check is recorded for the abandoned vector.
- SAMPLE: lasts one cycle. At the edge ending SAMPLE, i_f is compared to the expected value of the latched index, and then:
  - o_chk_cnt increments, saturating at all-ones.
  - o_cov[index] is set.
  - On mismatch, o_err_cnt increments, saturating at 2^ERR_W-1. If o_fail_vld=0, o_fail_vec takes the index and o_fail_vld goes to 1.
  - If o_cov is then 16'hFFFF, go to DONE; otherwise go to IDLE.
  - i_vld in SAMPLE is ignored.
- Latency: i_vld sampled at edge k means i_f is sampled, and the counters/flags update, at edge k+SETTLE_CYCLES+1.
- DONE: o_done=1 and o_pass=(o_err_cnt==0). i_vld is ignored. Only i_clr or i_rst leave DONE.
- Re-checking an already-covered vector is legal: it counts in o_chk_cnt and o_err_cnt, and o_cov is unchanged.
- o_fail_vec holds the first failure only and never updates after o_fail_vld=1.
- Reset asserted mid-SETTLE or mid-SAMPLE discards the pending check immediately, with no clock needed.

Test Plan:
1. Correct NAND4 model; indices 0..15 applied in order with i_vld every 10 cycles, SETTLE_CYCLES=4 -> o_done=1, o_pass=1, o_err_cnt=0, o_chk_cnt=16, o_cov=16'hFFFF, o_fail_vld=0.
2. i_f stuck at 1, sweep 0..15 -> o_err_cnt=1, o_fail_vec=4'hF, o_fail_vld=1, o_done=1, o_pass=0.
3. i_f stuck at 0, sweep 0..15 -> o_err_cnt=15, o_fail_vec=4'h0; with ERR_W=3 -> o_err_cnt saturates at 7.
4. Index 0 applied three times, then 1..15 -> o_chk_cnt=18, o_done rises only after index 15 is checked; an extra i_vld in DONE -> no counter change.
5. i_vld with index 5, then i_vld with index 6 two cycles later (mid-SETTLE) -> o_cov=16'h0040 only, o_chk_cnt=1, and the sample edge falls SETTLE_CYCLES+1 after the second strobe.
6. i_rst pulsed between clock edges mid-SETTLE -> all outputs 0 immediately. i_clr in DONE -> IDLE with all outputs 0 at the next edge. SETTLE_CYCLES=0 -> sample edge is k+1.

Source files
------------

// File: rtl/nand4_resp_checker.sv
// Response checker for any NAND4 variant: waits a settle time after each applied
// vector, compares the DUV output to the golden NAND4 value, and tracks errors/coverage.
module nand4_resp_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 5,
    parameter int CHK_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_vld,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_c,
    input  logic             i_d,
    input  logic             i_f,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [CHK_W-1:0] o_chk_cnt,
    output logic [15:0]      o_cov,
    output logic [3:0]       o_fail_vec,
    output logic             o_fail_vld
);

    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       vec_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ERR_W-1:0] err_q;
    logic [CHK_W-1:0] chk_q;
    logic [15:0]      cov_q;
    logic [3:0]       fail_vec_q;
    logic             fail_vld_q;

    logic [3:0]  vec_in;
    logic        exp_f;
    logic        mismatch;
    logic [15:0] cov_nxt;

    // i_vld is a one-cycle strobe with no back-pressure: it is taken in IDLE and
    // SETTLE (restarting the settle wait), and silently dropped in SAMPLE and DONE.
    assign vec_in   = {i_a, i_b, i_c, i_d};
    assign exp_f    = ~&vec_q;
    assign mismatch = (i_f != exp_f);
    assign cov_nxt  = cov_q | (16'd1 << vec_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else if (i_clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_vld) begin
                    state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                if (!i_vld && cnt_q == CNT_W'(1)) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                state_nxt = (cov_nxt == 16'hFFFF) ? DONE : IDLE;
            end
            default: state_nxt = DONE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        o_pass = 1'b0;
        if (state == SETTLE || state == SAMPLE) begin
            o_busy = 1'b1;
        end
        if (state == DONE) begin
            o_done = 1'b1;
            o_pass = (err_q == '0);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vec_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            chk_q      <= '0;
            cov_q      <= '0;
            fail_vec_q <= '0;
            fail_vld_q <= 1'b0;
        end else if (i_clr) begin
            vec_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            chk_q      <= '0;
            cov_q      <= '0;
            fail_vec_q <= '0;
            fail_vld_q <= 1'b0;
        end else begin
            if ((state == IDLE || state == SETTLE) && i_vld) begin
                vec_q <= vec_in;
                cnt_q <= SETTLE_LD;
            end else if (state == SETTLE) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            // The edge ending SAMPLE records the check for the latched vector.
            if (state == SAMPLE) begin
                cov_q <= cov_nxt;
                if (chk_q != '1) begin
                    chk_q <= chk_q + CHK_W'(1);
                end
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_q <= err_q + ERR_W'(1);
                    end
                    if (!fail_vld_q) begin
                        fail_vec_q <= vec_q;
                        fail_vld_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_err_cnt  = err_q;
    assign o_chk_cnt  = chk_q;
    assign o_cov      = cov_q;
    assign o_fail_vec = fail_vec_q;
    assign o_fail_vld = fail_vld_q;

endmodule

// File: tb/tb_nand4_resp_checker.sv
// Bench for nand4_resp_checker: directed vector sweeps with a scoreboard of expected
// check records (edge, counters, coverage, first-failure) popped as each check lands.
module tb_nand4_resp_checker;

  localparam int S = 4;

  typedef struct packed {
    logic [31:0] edge_n;
    logic [7:0]  chk;
    logic [4:0]  err;
    logic [15:0] cov;
    logic        fv;
    logic [3:0]  fvec;
    logic        done;
    logic        pass;
  } rec_t;

  logic clk, rst, clr, vld, a, b, c, d, f;
  logic [1:0] mode;  // 0: correct NAND4, 1: stuck at 1, 2: stuck at 0

  logic busy, done, pass, fvld;
  logic [4:0] err;
  logic [7:0] chk;
  logic [15:0] cov;
  logic [3:0] fvec;

  logic e3_busy, e3_done, e3_pass, e3_fvld;
  logic [2:0] e3_err;
  logic [7:0] e3_chk;
  logic [15:0] e3_cov;
  logic [3:0] e3_fvec;

  logic s0_busy, s0_done, s0_pass, s0_fvld;
  logic [4:0] s0_err;
  logic [7:0] s0_chk;
  logic [15:0] s0_cov;
  logic [3:0] s0_fvec;

  int total, bad;
  int cyc;
  bit mon_en;
  rec_t exp_q[$];

  logic [7:0]  m_chk;
  logic [4:0]  m_err;
  logic [15:0] m_cov;
  logic        m_fv;
  logic [3:0]  m_fvec;

  assign f = (mode == 2'd0) ? ~(a & b & c & d) : (mode == 2'd1);

  nand4_resp_checker #(.SETTLE_CYCLES(S), .ERR_W(5), .CHK_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_vld(vld),
    .i_a(a), .i_b(b), .i_c(c), .i_d(d), .i_f(f),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err),
    .o_chk_cnt(chk), .o_cov(cov), .o_fail_vec(fvec), .o_fail_vld(fvld)
  );

  nand4_resp_checker #(.SETTLE_CYCLES(S), .ERR_W(3), .CHK_W(8)) dut_e3 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_vld(vld),
    .i_a(a), .i_b(b), .i_c(c), .i_d(d), .i_f(f),
    .o_busy(e3_busy), .o_done(e3_done), .o_pass(e3_pass), .o_err_cnt(e3_err),
    .o_chk_cnt(e3_chk), .o_cov(e3_cov), .o_fail_vec(e3_fvec), .o_fail_vld(e3_fvld)
  );

  nand4_resp_checker #(.SETTLE_CYCLES(0), .ERR_W(5), .CHK_W(8)) dut_s0 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_vld(vld),
    .i_a(a), .i_b(b), .i_c(c), .i_d(d), .i_f(f),
    .o_busy(s0_busy), .o_done(s0_done), .o_pass(s0_pass), .o_err_cnt(s0_err),
    .o_chk_cnt(s0_chk), .o_cov(s0_cov), .o_fail_vec(s0_fvec), .o_fail_vld(s0_fvld)
  );

  // clock / reset-time edge counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnts"}, {19'd0, err, chk}, 32'd0);
    check({tag, "_flags"}, {24'd0, busy, done, pass, fvld, fvec}, 32'd0);
    check({tag, "_cov"}, {16'd0, cov}, 32'd0);
    check({tag, "_e3"}, {13'd0, e3_busy, e3_err, e3_chk, e3_fvld, e3_fvec}, 32'd0);
    check({tag, "_s0"}, {15'd0, s0_busy, s0_chk, s0_cov[7:0]}, 32'd0);
  endtask

  function automatic logic f_for(input logic [3:0] idx);
    return (mode == 2'd0) ? (idx != 4'hF) : (mode == 2'd1);
  endfunction

  task automatic model_reset();
    m_chk = '0; m_err = '0; m_cov = '0; m_fv = 1'b0; m_fvec = '0;
  endtask

  // Expected record for one completed check, landing at edge_at.
  task automatic push_exp(input logic [3:0] idx, input int edge_at);
    rec_t r;
    logic gold;
    gold = (idx != 4'hF);
    if (m_chk != 8'hFF) m_chk = m_chk + 8'd1;
    m_cov[idx] = 1'b1;
    if (f_for(idx) != gold) begin
      if (m_err != 5'h1F) m_err = m_err + 5'd1;
      if (!m_fv) begin
        m_fv = 1'b1;
        m_fvec = idx;
      end
    end
    r.edge_n = edge_at;
    r.chk = m_chk; r.err = m_err; r.cov = m_cov;
    r.fv = m_fv; r.fvec = m_fvec;
    r.done = (m_cov == 16'hFFFF);
    r.pass = r.done && (m_err == 5'd0);
    exp_q.push_back(r);
  endtask

  // driver: present a vector with i_vld for one edge
  task automatic drive(input logic [3:0] idx, input bit push);
    @(posedge clk);
    #1;
    {a, b, c, d} = idx;
    vld = 1'b1;
    if (push) push_exp(idx, cyc + 1 + S + 1);
  endtask

  task automatic apply(input logic [3:0] idx, input bit push);
    drive(idx, push);
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  task automatic step(input logic [3:0] idx);
    apply(idx, 1'b1);
    repeat (8) @(posedge clk);
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) step(4'(i));
  endtask

  task automatic clear_all(input string tag);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_reset();
    @(negedge clk);
    check_all_zero(tag);
  endtask

  // scoreboard monitor: a check has landed when busy falls
  initial begin
    rec_t e, act;
    bit prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && prev_busy && !busy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_check: cyc=%0d chk=%0d cov=%h, none expected", cyc, chk, cov);
        end else begin
          e = exp_q.pop_front();
          act.edge_n = cyc; act.chk = chk; act.err = err; act.cov = cov;
          act.fv = fvld; act.fvec = fvec; act.done = done; act.pass = pass;
          if (act !== e) begin
            bad++;
            $display("FAIL check_record: got edge=%0d chk=%0d err=%0d cov=%h fv=%b fvec=%h done=%b pass=%b expected edge=%0d chk=%0d err=%0d cov=%h fv=%b fvec=%h done=%b pass=%b",
                     act.edge_n, act.chk, act.err, act.cov, act.fv, act.fvec, act.done, act.pass,
                     e.edge_n, e.chk, e.err, e.cov, e.fv, e.fvec, e.done, e.pass);
          end
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    total = 0; bad = 0; cyc = 0; mon_en = 1'b0;
    mode = 2'd0; rst = 1'b1; clr = 1'b0; vld = 1'b0;
    {a, b, c, d} = 4'h0;
    model_reset();
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // correct DUV, full sweep
    mode = 2'd0;
    sweep();
    @(negedge clk);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_pass", {31'd0, pass}, 32'd1);
    check("t1_err", {27'd0, err}, 32'd0);
    check("t1_chk", {24'd0, chk}, 32'd16);
    check("t1_cov", {16'd0, cov}, 32'h0000FFFF);
    check("t1_fvld", {31'd0, fvld}, 32'd0);
    check("t1_s0_pass", {30'd0, s0_done, s0_pass}, 32'd3);
    apply(4'h9, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t1_done_ignores_vld", {23'd0, busy, chk}, 32'd16);
    clear_all("clr_in_done");

    // stuck at 1: only index 15 fails
    mode = 2'd1;
    sweep();
    @(negedge clk);
    check("t2_err", {27'd0, err}, 32'd1);
    check("t2_fail", {27'd0, fvld, fvec}, 32'h1F);
    check("t2_done_pass", {30'd0, done, pass}, 32'd2);
    check("t2_e3_err", {29'd0, e3_err}, 32'd1);
    clear_all("clr2");

    // stuck at 0: indices 0..14 fail, narrow counter saturates
    mode = 2'd2;
    sweep();
    @(negedge clk);
    check("t3_err", {27'd0, err}, 32'd15);
    check("t3_fail", {27'd0, fvld, fvec}, 32'h10);
    check("t3_e3_err_sat", {29'd0, e3_err}, 32'd7);
    check("t3_e3_fail", {27'd0, e3_fvld, e3_fvec}, 32'h10);
    check("t3_chk", {24'd0, chk}, 32'd16);
    clear_all("clr3");

    // repeated index 0, then 1..15
    mode = 2'd0;
    repeat (3) step(4'h0);
    for (int i = 1; i < 16; i++) step(4'(i));
    @(negedge clk);
    check("t4_chk", {24'd0, chk}, 32'd18);
    check("t4_done", {30'd0, done, pass}, 32'd3);
    apply(4'hF, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_done_ignores_vld", {19'd0, err, chk}, 32'd18);
    clear_all("clr4");

    // restart mid-SETTLE: 5 abandoned, only 6 checked
    apply(4'h5, 1'b0);
    apply(4'h6, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t5_cov", {16'd0, cov}, 32'h00000040);
    check("t5_chk", {24'd0, chk}, 32'd1);
    clear_all("clr5");

    // async reset mid-SETTLE
    apply(4'h3, 1'b0);
    @(posedge clk);
    #2;
    check("t6_busy_before_rst", {31'd0, busy}, 32'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("t6_async_rst");
    #1 rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t6_no_late_check", {23'd0, busy, chk}, 32'd0);

    // zero settle: sample edge is k+1
    drive(4'hA, 1'b1);
    @(posedge clk);
    #1 vld = 1'b0;
    @(negedge clk);
    check("t6_s0_in_sample", {23'd0, s0_busy, s0_chk}, 32'h100);
    @(negedge clk);
    check("t6_s0_checked", {23'd0, s0_busy, s0_chk}, 32'd1);
    check("t6_s0_cov", {16'd0, s0_cov}, 32'h00000400);
    check("t6_s0_err", {26'd0, s0_fvld, s0_err}, 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t6_dut_chk", {24'd0, chk}, 32'd1);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
